// File: rtl/sync_pkg.sv
// Shared types and defaults for the synchronization block.
// Scheduler state and fault-cause encodings live here.
package sync_pkg;

  localparam int unsigned SHOT_TIMEOUT_DEF = 1_000_000;
  localparam int unsigned HOLDOFF_DEF      = 500_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DET,
    S_WAIT_TRIG_HI,
    S_WAIT_TRIG_LO,
    S_HOLDOFF,
    S_DONE,
    S_FAULT
  } sched_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_TIMEOUT = 2'd1,
    FC_ABORT   = 2'd2
  } fault_code_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down counter shared by the shot watchdog and the holdoff.
// Expired flags the last allowed cycle of a window (count == 1).
module cycle_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/experiment_scheduler.sv
// Multi-shot sequencer in front of the experiment FSM.
// Issues start pulses, tracks each shot, enforces holdoff and watchdog.
module experiment_scheduler
  import sync_pkg::*;
#(
  parameter int unsigned SHOT_TIMEOUT = SHOT_TIMEOUT_DEF,
  parameter int unsigned HOLDOFF      = HOLDOFF_DEF,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       arm,
  input  logic [7:0] shot_count,
  input  logic       abort,
  input  logic       fault_clear,
  input  logic       exp_detonation,
  input  logic       exp_trigger,
  output logic       exp_start,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] shots_done
);

  sched_state_t     state_q, state_d;
  fault_code_t      code_q, code_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       shots_q, shots_d;
  logic             exp_start_q, busy_q, done_q, fault_q;
  logic             tmr_load, tmr_expired;
  logic [CNT_W-1:0] tmr_value;
  logic             watched, active;

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  assign watched = state_q inside {S_WAIT_DET, S_WAIT_TRIG_HI,
                                   S_WAIT_TRIG_LO};
  assign active  = watched || state_q inside {S_ISSUE, S_HOLDOFF};

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    count_d   = count_q;
    shots_d   = shots_q;
    tmr_load  = 1'b0;
    tmr_value = CNT_W'(SHOT_TIMEOUT);
    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          count_d = shot_count;
          shots_d = '0;
          state_d = (shot_count != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        tmr_load = 1'b1;
        state_d  = S_WAIT_DET;
      end
      S_WAIT_DET: begin
        if (exp_detonation) state_d = S_WAIT_TRIG_HI;
      end
      S_WAIT_TRIG_HI: begin
        if (exp_trigger) state_d = S_WAIT_TRIG_LO;
      end
      S_WAIT_TRIG_LO: begin
        if (!exp_trigger) begin
          shots_d = shots_q + 8'd1;
          if (shots_q + 8'd1 == count_q) begin
            state_d = S_DONE;
          end else begin
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(HOLDOFF);
            state_d   = S_HOLDOFF;
          end
        end
      end
      S_HOLDOFF: begin
        if (tmr_expired) state_d = S_ISSUE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clear) begin
          state_d = S_IDLE;
          code_d  = FC_NONE;
        end
      end
    endcase
    // Abort outranks the watchdog, which outranks shot progress.
    if (watched && tmr_expired) begin
      state_d  = S_FAULT;
      code_d   = FC_TIMEOUT;
      shots_d  = shots_q;
      tmr_load = 1'b0;
    end
    if (active && abort) begin
      state_d  = S_FAULT;
      code_d   = FC_ABORT;
      shots_d  = shots_q;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      code_q  <= FC_NONE;
      count_q <= '0;
      shots_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      count_q <= count_d;
      shots_q <= shots_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      exp_start_q <= (state_q == S_ISSUE);
      busy_q      <= !(state_q inside {S_IDLE, S_FAULT});
      done_q      <= (state_q == S_DONE);
      fault_q     <= (state_q == S_FAULT);
    end
  end

  assign exp_start  = exp_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign shots_done = shots_q;

endmodule

// File: tb/tb_experiment_scheduler.sv
// Bench for experiment_scheduler: vector table, directed corners
// and randomized runs scored by a shot-level timing model.
module tb_experiment_scheduler;

  localparam int L = 100;
  localparam int H = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       arm = 1'b0;
  logic [7:0] shot_count = 8'd0;
  logic       abort = 1'b0;
  logic       fault_clear = 1'b0;
  logic       exp_detonation = 1'b0;
  logic       exp_trigger = 1'b0;
  logic       exp_start, busy, done, fault;
  logic [1:0] fault_code;
  logic [7:0] shots_done;

  experiment_scheduler #(
    .SHOT_TIMEOUT(L), .HOLDOFF(H), .CNT_W(32)
  ) dut (
    .clock(clock), .reset_n(reset_n), .arm(arm),
    .shot_count(shot_count), .abort(abort),
    .fault_clear(fault_clear),
    .exp_detonation(exp_detonation), .exp_trigger(exp_trigger),
    .exp_start(exp_start), .busy(busy), .done(done),
    .fault(fault), .fault_code(fault_code),
    .shots_done(shots_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int n; int a; int b; int w; int abort_at;
    int exp_shots; int exp_code; int exp_starts; int exp_done;
  } vec_t;

  vec_t vecs[7];
  int tests = 0;
  int failed = 0;
  int cyc_n = 0;
  int n_start, n_done, start_cyc, done_cyc, fault_cyc;
  int pa[8], pb[8], pw[8];

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc_n++;
    if (exp_start) begin n_start++; start_cyc = cyc_n; end
    if (done) begin n_done++; done_cyc = cyc_n; end
    if (fault && fault_cyc < 0) fault_cyc = cyc_n;
  endtask

  task automatic clr_counts();
    n_start = 0; n_done = 0;
    start_cyc = -1; done_cyc = -1; fault_cyc = -1;
  endtask

  // Responder: det after a cycles, trigger b cycles later, w cycles wide.
  task automatic shot_wave(input int a, input int b, input int w,
                           output int tf);
    repeat (a) tick();
    exp_detonation = 1'b1; tick();
    exp_detonation = 1'b0;
    repeat (b) tick();
    exp_trigger = 1'b1;
    repeat (w) tick();
    exp_trigger = 1'b0;
    tf = cyc_n + 1;
    tick();
  endtask

  task automatic run(input int n, input int abort_at);
    int prev, tf, k, arm_cyc, shots, abort_cyc;
    clr_counts();
    tf = -1; shots = 0; prev = 0; abort_cyc = -1;
    shot_count = n[7:0]; arm = 1'b1; arm_cyc = cyc_n;
    tick();
    arm = 1'b0; shot_count = 8'd0;
    while (1) begin
      k = 0;
      while (n_start == prev && done_cyc < 0 && fault_cyc < 0 && k < 400) begin
        tick(); k++;
      end
      if (k >= 400) begin chk("event_wait_timeout", k, 0); break; end
      if (n_start == prev) break;
      prev = n_start;
      if (tf >= 0) chk("holdoff_spacing", start_cyc - tf, H + 1);
      if (prev == 1) chk("busy_in_run", int'(busy), 1);
      shot_wave(pa[shots], pb[shots], pw[shots], tf);
      shots++;
      if (shots == abort_at) begin
        abort = 1'b1; abort_cyc = cyc_n; tick(); abort = 1'b0;
      end
    end
    repeat (20) tick();
    if (done_cyc >= 0 && tf >= 0) chk("done_latency", done_cyc - tf, 1);
    if (done_cyc >= 0 && tf < 0) chk("zero_shot_latency", done_cyc - arm_cyc, 2);
    if (abort_cyc >= 0) chk("abort_latency", fault_cyc - abort_cyc, 2);
    if (fault && fault_code == 2'd1)
      chk("watchdog_latency", fault_cyc - start_cyc, L + 1);
  endtask

  task automatic finish_run(input string tag, input int e_shots,
                            input int e_code, input int e_starts,
                            input int e_done);
    chk({tag, ".shots_done"}, int'(shots_done), e_shots);
    chk({tag, ".fault_code"}, int'(fault_code), e_code);
    chk({tag, ".fault"}, int'(fault), int'(e_code != 0));
    chk({tag, ".starts"}, n_start, e_starts);
    chk({tag, ".done_pulses"}, n_done, e_done);
    chk({tag, ".busy_after"}, int'(busy), 0);
    if (fault) begin
      fault_clear = 1'b1; tick(); fault_clear = 1'b0;
      tick(); tick();
      chk({tag, ".fault_cleared"}, int'(fault), 0);
      chk({tag, ".code_cleared"}, int'(fault_code), 0);
    end
  endtask

  initial begin
    int n, k, e_shots, e_code, e_starts, e_done;
    vecs[0] = '{3, 2, 1, 2, 0, 3, 0, 3, 1};
    vecs[1] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    vecs[2] = '{1, 96, 0, 1, 0, 1, 0, 1, 1};
    vecs[3] = '{1, 97, 0, 1, 0, 0, 1, 1, 0};
    vecs[4] = '{2, 0, 0, 1, 0, 2, 0, 2, 1};
    vecs[5] = '{2, 250, 0, 1, 0, 0, 1, 1, 0};
    vecs[6] = '{3, 1, 1, 1, 1, 1, 2, 1, 0};
    clr_counts();

    #3 reset_n = 1'b0;
    #1;
    chk("rst.exp_start", int'(exp_start), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.fault", int'(fault), 0);
    chk("rst.fault_code", int'(fault_code), 0);
    chk("rst.shots_done", int'(shots_done), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    chk("idle_abort.fault", int'(fault), 0);
    chk("idle_abort.busy", int'(busy), 0);

    foreach (vecs[i]) begin
      for (int j = 0; j < 8; j++) begin
        pa[j] = vecs[i].a; pb[j] = vecs[i].b; pw[j] = vecs[i].w;
      end
      run(vecs[i].n, vecs[i].abort_at);
      finish_run($sformatf("vec%0d", i), vecs[i].exp_shots,
                 vecs[i].exp_code, vecs[i].exp_starts, vecs[i].exp_done);
    end

    // abort landing on the watchdog expiry cycle
    clr_counts();
    shot_count = 8'd1; arm = 1'b1; tick(); arm = 1'b0;
    k = 0;
    while (n_start == 0 && k < 20) begin tick(); k++; end
    if (k >= 20) chk("abort_wd.start_timeout", k, 0);
    while (cyc_n < start_cyc + L - 1) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    tick(); tick();
    chk("abort_wd.fault_code", int'(fault_code), 2);
    chk("abort_wd.fault_lat", fault_cyc - start_cyc, L + 1);
    finish_run("abort_wd", 0, 2, 1, 0);

    // reset while waiting for trigger fall
    clr_counts();
    shot_count = 8'd2; arm = 1'b1; tick(); arm = 1'b0;
    k = 0;
    while (n_start == 0 && k < 20) begin tick(); k++; end
    if (k >= 20) chk("rst_mid.start_timeout", k, 0);
    exp_detonation = 1'b1; tick();
    exp_detonation = 1'b0; exp_trigger = 1'b1;
    tick(); tick();
    chk("rst_mid.busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.busy", int'(busy), 0);
    chk("rst_mid.exp_start", int'(exp_start), 0);
    chk("rst_mid.fault", int'(fault), 0);
    chk("rst_mid.shots_done", int'(shots_done), 0);
    exp_trigger = 1'b0;
    tick();
    reset_n = 1'b1;
    clr_counts();
    repeat (15) tick();
    chk("rst_mid.no_start", n_start, 0);
    for (int j = 0; j < 8; j++) begin pa[j] = 3; pb[j] = 1; pw[j] = 1; end
    run(1, 0);
    finish_run("rst_mid.rerun", 1, 0, 1, 1);

    // randomized runs against the shot-level timing model
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < 8; j++) begin
        pa[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(85, 100)
                                            : $urandom_range(0, 15);
        pb[j] = $urandom_range(0, 12);
        pw[j] = $urandom_range(1, 4);
      end
      e_shots = n; e_code = 0;
      for (int j = 0; j < n; j++) begin
        if (e_code == 0 && pa[j] + pb[j] + pw[j] + 2 >= L) begin
          e_shots = j; e_code = 1;
        end
      end
      e_starts = (e_code != 0) ? e_shots + 1 : n;
      e_done = (e_code != 0) ? 0 : 1;
      run(n, 0);
      finish_run($sformatf("rand%0d", r), e_shots, e_code,
                 e_starts, e_done);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: sim time limit reached");
    $fatal(1);
  end

endmodule
